// File: rtl/uart_tx_ctrl_pkg.sv
// Shared UART transmit definitions: controller state encoding and frame-bit
// select codes, used by the controller and the TX top level.
package uart_tx_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] MUX_START  = 2'b00;
  localparam logic [1:0] MUX_IDLE   = 2'b01;
  localparam logic [1:0] MUX_DATA   = 2'b10;
  localparam logic [1:0] MUX_PARITY = 2'b11;

  // IDLE and STOP both present the mark level on the line.
  function automatic logic [1:0] mux_for_state(input tx_state_t state);
    case (state)
      S_START:  return MUX_START;
      S_DATA:   return MUX_DATA;
      S_PARITY: return MUX_PARITY;
      default:  return MUX_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_parity_calc.sv
// Parity bit generator: XOR reduction of the data word, inverted for odd parity.
module parity_calc #(
  parameter int Data_width = 8
) (
  input  logic [Data_width-1:0] i_data,
  input  logic                  i_type,
  output logic                  o_par_bit
);

  assign o_par_bit = (^i_data) ^ i_type;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frame sequencing FSM, request capture and the
// registered serial line output.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int Data_width = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [Data_width-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_en,
  output logic [1:0]            mux_sel,
  output logic                  TX_OUT,
  output logic                  Busy
);

  tx_state_t             r_state;
  tx_state_t             w_state_next;
  logic [Data_width-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  w_accept;
  logic                  w_par_bit;
  logic                  w_line_bit;

  // STOP accepts a new request so back-to-back frames have no idle gap.
  assign w_accept = Data_Valid && ((r_state == S_IDLE) || (r_state == S_STOP));

  parity_calc #(
    .Data_width(Data_width)
  ) u_parity_calc (
    .i_data   (r_data),
    .i_type   (r_par_typ),
    .o_par_bit(w_par_bit)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      TX_OUT    <= 1'b1;
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
    end else begin
      r_state <= w_state_next;
      TX_OUT  <= w_line_bit;
      if (w_accept) begin
        r_data    <= P_DATA;
        r_par_en  <= PAR_EN;
        r_par_typ <= PAR_TYP;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    ser_en       = 1'b0;
    mux_sel      = mux_for_state(r_state);
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_START;
      end
      S_START: begin
        w_state_next = S_DATA;
      end
      S_DATA: begin
        ser_en = 1'b1;
        if (ser_done) w_state_next = r_par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        w_state_next = S_STOP;
      end
      S_STOP: begin
        w_state_next = w_accept ? S_START : S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_line_bit = 1'b1;
    case (mux_sel)
      MUX_START:  w_line_bit = 1'b0;
      MUX_IDLE:   w_line_bit = 1'b1;
      MUX_DATA:   w_line_bit = ser_data;
      MUX_PARITY: w_line_bit = w_par_bit;
      default:    w_line_bit = 1'b1;
    endcase
  end

  assign Busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a cycle-indexed timeline of expected outputs is
// built from each accepted request, then compared against the DUT every cycle.
module tb_uart_tx_ctrl;

  localparam int NCYC = 4096;
  localparam int NA   = NCYC + 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] p_data = '0;
  logic       data_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic       ser_data;
  logic       ser_done;
  logic       ser_en;
  logic [1:0] mux_sel;
  logic       tx_out;
  logic       busy;

  uart_tx_ctrl #(.Data_width(8)) dut (
    .CLK       (clk),
    .RST       (rst),
    .P_DATA    (p_data),
    .Data_Valid(data_valid),
    .PAR_EN    (par_en),
    .PAR_TYP   (par_typ),
    .ser_data  (ser_data),
    .ser_done  (ser_done),
    .ser_en    (ser_en),
    .mux_sel   (mux_sel),
    .TX_OUT    (tx_out),
    .Busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream serializer: loads on the start-bit select, shifts LSB first.
  logic [7:0] ser_load_data = '0;
  logic [7:0] ser_sr = '0;
  int         ser_cnt = 0;
  always @(posedge clk) begin
    if (mux_sel == 2'b00) begin
      ser_sr  <= ser_load_data;
      ser_cnt <= 0;
    end else if (ser_en) begin
      ser_sr  <= ser_sr >> 1;
      ser_cnt <= ser_cnt + 1;
    end
  end
  assign ser_data = ser_sr[0];
  assign ser_done = (ser_cnt == 7);

  // Expected outputs per cycle.
  logic       exp_tx   [NA];
  logic       exp_busy [NA];
  logic [1:0] exp_mux  [NA];
  logic       exp_sen  [NA];
  int         last_end = 0;
  int         last_acc = 0;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input int c, input logic [7:0] got, input logic [7:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, c, got, exp);
  endtask

  initial begin
    for (int t = 0; t < NA; t++) begin
      exp_tx[t] = 1'b1; exp_busy[t] = 1'b0; exp_mux[t] = 2'b01; exp_sen[t] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cyc >= 2 && cyc < NCYC) begin
      chk("tx_out",  cyc, {7'd0, tx_out}, {7'd0, exp_tx[cyc]});
      chk("busy",    cyc, {7'd0, busy},   {7'd0, exp_busy[cyc]});
      chk("mux_sel", cyc, {6'd0, mux_sel}, {6'd0, exp_mux[cyc]});
      chk("ser_en",  cyc, {7'd0, ser_en}, {7'd0, exp_sen[cyc]});
    end
  end

  // One cycle of stimulus; the model decides acceptance from frame timing alone.
  task automatic step(input logic dv, input logic [7:0] d, input logic pe, input logic pt, input logic r);
    int c;
    int len;
    @(negedge clk);
    c = cyc;
    rst = r; data_valid = dv; p_data = d; par_en = pe; par_typ = pt;
    if (r) begin
      for (int t = c + 1; t < NA; t++) begin
        exp_tx[t] = 1'b1; exp_busy[t] = 1'b0; exp_mux[t] = 2'b01; exp_sen[t] = 1'b0;
      end
      last_end = c;
    end else if (dv && c >= last_end) begin
      len = pe ? 11 : 10;
      for (int t = c + 1; t <= c + len; t++) exp_busy[t] = 1'b1;
      exp_mux[c + 1] = 2'b00;
      exp_tx[c + 2]  = 1'b0;
      for (int k = 0; k < 8; k++) begin
        exp_mux[c + 2 + k] = 2'b10;
        exp_sen[c + 2 + k] = 1'b1;
        exp_tx[c + 3 + k]  = d[k];
      end
      if (pe) begin
        exp_mux[c + 10] = 2'b11;
        exp_tx[c + 11]  = (^d) ^ pt;
      end
      exp_mux[c + len]    = 2'b01;
      exp_tx[c + len + 1] = 1'b1;
      last_end = c + len;
      last_acc = c;
      ser_load_data = d;
      $display("frame accepted cyc=%0d data=%02h par_en=%0d par_typ=%0d", c, d, pe, pt);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
  endtask

  function automatic int busy_count(input int a, input int b);
    int n = 0;
    for (int t = a; t <= b; t++) if (exp_busy[t]) n++;
    return n;
  endfunction

  logic [10:0] a5_even = 11'b10101001010;  // cycles c+2..c+12, bit i = cycle c+2+i
  int c0;

  initial begin
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h12, 1'b0, 1'b0, 1'b1);  // reset wins over Data_Valid
    idle(2);

    step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    c0 = last_acc;
    for (int i = 0; i < 11; i++) chk("model_a5_even", c0 + 2 + i, {7'd0, exp_tx[c0 + 2 + i]}, {7'd0, a5_even[i]});
    chk("model_a5_busy", c0, 8'(busy_count(c0, c0 + 14)), 8'd11);
    idle(14);

    step(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);
    c0 = last_acc;
    chk("model_a5_odd_par", c0 + 11, {7'd0, exp_tx[c0 + 11]}, 8'd1);
    idle(14);

    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    c0 = last_acc;
    chk("model_00_busy", c0, 8'(busy_count(c0, c0 + 14)), 8'd10);
    idle(14);

    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    c0 = last_acc;
    idle(9);
    step(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
    chk("model_b2b_busy", c0, 8'(busy_count(c0 + 1, c0 + 20)), 8'd20);
    chk("model_b2b_start", c0 + 12, {7'd0, exp_tx[c0 + 12]}, 8'd0);
    idle(14);

    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    c0 = last_acc;
    idle(3);
    step(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
    idle(12);
    chk("model_ignore_busy", c0, 8'(busy_count(c0, c0 + 15)), 8'd10);

    step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    c0 = last_acc;
    idle(4);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);  // 4th DATA cycle
    chk("model_abort_tx", c0 + 6, {7'd0, exp_tx[c0 + 6]}, 8'd1);
    chk("model_abort_busy", c0 + 6, {7'd0, exp_busy[c0 + 6]}, 8'd0);
    idle(2);
    step(1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
    idle(14);

    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0, 8'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end
    idle(16);
    @(negedge clk);
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
